hms_timekeeper: RTL and testbench

Parametrised, single-clock-domain time-of-day core. It replaces the gated-clock second/minute/hour counter chain and its mode controller with one synchronous block. Internal tick enables replace derived clocks. The block adds an alarm register set with its own setup mode and a timed alarm output. It sits between the debounced switch pulses and the digit-split/FND display path.

---
 rtl/hms_timekeeper.sv | 185 ++++++++++++++++++
 tb/tb_hms_timekeeper.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hms_timekeeper.sv
// Single-clock time-of-day core with a one-second tick prescaler, a setup/alarm-set mode FSM,
// field editing, and a timed alarm output. The displayed fields are registered.
module hms_timekeeper #(
  parameter int TICK_DIV  = 50000000,
  parameter int HR_MAX    = 23,
  parameter int ALARM_LEN = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_mode_pulse,
  input  logic       i_pos_pulse,
  input  logic       i_inc_pulse,
  input  logic       i_alarm_en,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [5:0] o_hr,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_tick,
  output logic       o_alarm
);

  localparam int              CW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   PRESC_LAST = CW'(TICK_DIV - 1);
  localparam logic [5:0]      MS_LAST    = 6'd59;
  localparam logic [5:0]      HR_LAST    = 6'(HR_MAX);
  localparam logic [7:0]      ALARM_LOAD = 8'(ALARM_LEN);

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'd0,
    MODE_SETUP     = 2'd1,
    MODE_ALARM_SET = 2'd2,
    MODE_BAD       = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    POS_SEC = 2'd0,
    POS_MIN = 2'd1,
    POS_HR  = 2'd2,
    POS_BAD = 2'd3
  } pos_t;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] last);
    return (v == last) ? 6'd0 : v + 6'd1;
  endfunction

  mode_t         mode_q, mode_d;
  pos_t          pos_q, pos_d;
  logic [CW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, min_q, hr_q, sec_d, min_d, hr_d;
  logic [5:0]    al_sec_q, al_min_q, al_hr_q, al_sec_d, al_min_d, al_hr_d;
  logic          alarm_q, alarm_d;
  logic [7:0]    dur_q, dur_d;
  logic [5:0]    disp_sec, disp_min, disp_hr;
  logic          tick, running, editing, pos_adv, inc_ok, match;

  assign tick       = (presc_q == PRESC_LAST);
  assign running    = (mode_q == MODE_CLOCK) || (mode_q == MODE_ALARM_SET);
  assign editing    = (mode_q == MODE_SETUP) || (mode_q == MODE_ALARM_SET);
  assign pos_adv    = !i_mode_pulse && i_pos_pulse && editing;
  assign inc_ok     = !i_mode_pulse && !i_pos_pulse && i_inc_pulse && editing;
  assign o_tick     = tick;
  assign o_mode     = mode_q;
  assign o_position = pos_q;
  assign o_alarm    = alarm_q;

  always_comb begin
    mode_d   = mode_q;
    pos_d    = pos_q;
    presc_d  = tick ? '0 : presc_q + CW'(1);
    sec_d    = sec_q;
    min_d    = min_q;
    hr_d     = hr_q;
    al_sec_d = al_sec_q;
    al_min_d = al_min_q;
    al_hr_d  = al_hr_q;
    alarm_d  = alarm_q;
    dur_d    = dur_q;
    match    = 1'b0;

    case (mode_q)
      MODE_CLOCK:     if (i_mode_pulse) mode_d = MODE_SETUP;
      MODE_SETUP:     if (i_mode_pulse) mode_d = MODE_ALARM_SET;
      MODE_ALARM_SET: if (i_mode_pulse) mode_d = MODE_CLOCK;
      default:        mode_d = MODE_CLOCK;
    endcase

    if (mode_d != mode_q) begin
      pos_d = POS_SEC;
    end else if (pos_q == POS_BAD) begin
      pos_d = POS_SEC;
    end else if (pos_adv) begin
      case (pos_q)
        POS_SEC: pos_d = POS_MIN;
        POS_MIN: pos_d = POS_HR;
        default: pos_d = POS_SEC;
      endcase
    end

    // Restart the second on re-entry to CLOCK so the first second is full length.
    if (mode_d == MODE_CLOCK && mode_q != MODE_CLOCK) presc_d = '0;

    if (tick && running) begin
      sec_d = wrap_inc(sec_q, MS_LAST);
      if (sec_q == MS_LAST) begin
        min_d = wrap_inc(min_q, MS_LAST);
        if (min_q == MS_LAST) hr_d = wrap_inc(hr_q, HR_LAST);
      end
    end

    if (inc_ok && mode_q == MODE_SETUP) begin
      case (pos_q)
        POS_SEC: sec_d = wrap_inc(sec_q, MS_LAST);
        POS_MIN: min_d = wrap_inc(min_q, MS_LAST);
        POS_HR:  hr_d  = wrap_inc(hr_q, HR_LAST);
        default: ;
      endcase
    end

    if (inc_ok && mode_q == MODE_ALARM_SET) begin
      case (pos_q)
        POS_SEC: al_sec_d = wrap_inc(al_sec_q, MS_LAST);
        POS_MIN: al_min_d = wrap_inc(al_min_q, MS_LAST);
        POS_HR:  al_hr_d  = wrap_inc(al_hr_q, HR_LAST);
        default: ;
      endcase
    end

    // Only tick-driven advances can match; edits in SETUP never raise the alarm.
    match = tick && running && i_alarm_en &&
            ({hr_d, min_d, sec_d} == {al_hr_q, al_min_q, al_sec_q});

    if (alarm_q && tick) begin
      dur_d   = (dur_q == 8'd0) ? 8'd0 : dur_q - 8'd1;
      alarm_d = (dur_d != 8'd0);
    end
    if (match) begin
      alarm_d = 1'b1;
      dur_d   = ALARM_LOAD;
    end
    if (!i_alarm_en || i_mode_pulse) begin
      alarm_d = 1'b0;
      dur_d   = 8'd0;
    end

    disp_sec = (mode_d == MODE_ALARM_SET) ? al_sec_d : sec_d;
    disp_min = (mode_d == MODE_ALARM_SET) ? al_min_d : min_d;
    disp_hr  = (mode_d == MODE_ALARM_SET) ? al_hr_d  : hr_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= MODE_CLOCK;
      pos_q    <= POS_SEC;
      presc_q  <= '0;
      sec_q    <= 6'd0;
      min_q    <= 6'd0;
      hr_q     <= 6'd0;
      al_sec_q <= 6'd0;
      al_min_q <= 6'd0;
      al_hr_q  <= 6'd0;
      alarm_q  <= 1'b0;
      dur_q    <= 8'd0;
      o_sec    <= 6'd0;
      o_min    <= 6'd0;
      o_hr     <= 6'd0;
    end else begin
      mode_q   <= mode_d;
      pos_q    <= pos_d;
      presc_q  <= presc_d;
      sec_q    <= sec_d;
      min_q    <= min_d;
      hr_q     <= hr_d;
      al_sec_q <= al_sec_d;
      al_min_q <= al_min_d;
      al_hr_q  <= al_hr_d;
      alarm_q  <= alarm_d;
      dur_q    <= dur_d;
      o_sec    <= disp_sec;
      o_min    <= disp_min;
      o_hr     <= disp_hr;
    end
  end

endmodule

// File: tb/tb_hms_timekeeper.sv
// Directed bench for hms_timekeeper with TICK_DIV=4, HR_MAX=23, ALARM_LEN=3;
// expected values are hand-computed edge counts relative to reset release or CLOCK entry.
module tb_hms_timekeeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_mode_pulse = 1'b0;
  logic       i_pos_pulse  = 1'b0;
  logic       i_inc_pulse  = 1'b0;
  logic       i_alarm_en   = 1'b0;
  logic [5:0] o_sec, o_min, o_hr;
  logic [1:0] o_mode, o_position;
  logic       o_tick, o_alarm;

  int checks = 0;
  int errors = 0;

  hms_timekeeper #(.TICK_DIV(4), .HR_MAX(23), .ALARM_LEN(3)) dut (
    .clk(clk), .rst(rst),
    .i_mode_pulse(i_mode_pulse), .i_pos_pulse(i_pos_pulse), .i_inc_pulse(i_inc_pulse),
    .i_alarm_en(i_alarm_en),
    .o_sec(o_sec), .o_min(o_min), .o_hr(o_hr),
    .o_mode(o_mode), .o_position(o_position),
    .o_tick(o_tick), .o_alarm(o_alarm)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle of pulses, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic m, input logic p, input logic i);
    i_mode_pulse = m;
    i_pos_pulse  = p;
    i_inc_pulse  = i;
    @(posedge clk);
    #1;
    i_mode_pulse = 1'b0;
    i_pos_pulse  = 1'b0;
    i_inc_pulse  = 1'b0;
  endtask

  task automatic checkTime(input string tag, input int h, input int m, input int s);
    checkOutput({tag, "_hr"}, o_hr, h);
    checkOutput({tag, "_min"}, o_min, m);
    checkOutput({tag, "_sec"}, o_sec, s);
  endtask

  // Leaves SETUP through ALARM_SET without a tick landing there; prescaler is 0 on CLOCK entry.
  task automatic enterClockAligned(input string tag);
    int n = 0;
    while (!o_tick && n < 8) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput({tag, "_tick_wait"}, o_tick, 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput({tag, "_mode_clock"}, o_mode, 0);
  endtask

  // In SETUP: increment the selected field until it reads the target (stimulus only).
  task automatic incUntil(input int sel, input int target);
    for (int n = 0; n < 64; n++) begin
      if ((sel == 0 ? int'(o_sec) : sel == 1 ? int'(o_min) : int'(o_hr)) == target) break;
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic runAlarm(input string tag, input int drop_k, input int stop_k);
    int fall_k;
    i_alarm_en = 1'b0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput({tag, "_alarm_reg_sec"}, o_sec, 5);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput({tag, "_in_setup"}, o_mode, 1);
    incUntil(0, 0);
    checkTime({tag, "_zeroed"}, 0, 0, 0);
    enterClockAligned(tag);
    i_alarm_en = 1'b1;
    fall_k = (drop_k > 0) ? drop_k + 1 : 32;
    for (int k = 1; k <= stop_k; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput({tag, "_alarm"}, o_alarm, (k >= 20 && k < fall_k) ? 1 : 0);
      if (k % 4 == 0) checkOutput({tag, "_sec"}, o_sec, k / 4);
      if (k == drop_k) i_alarm_en = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkTime("reset", 0, 0, 0);
    checkOutput("reset_mode", o_mode, 0);
    checkOutput("reset_pos", o_position, 0);
    checkOutput("reset_tick", o_tick, 0);
    checkOutput("reset_alarm", o_alarm, 0);
    rst = 1'b0;

    // Free-running ticks every 4 cycles
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("run_tick", o_tick, (k % 4 == 3) ? 1 : 0);
      if (k % 4 == 0) checkOutput("run_sec", o_sec, k / 4);
      checkOutput("run_mode", o_mode, 0);
      checkOutput("run_alarm", o_alarm, 0);
    end

    // SETUP editing: hour wraps without carry
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("setup_mode", o_mode, 1);
    checkOutput("setup_pos0", o_position, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("setup_pos_hr", o_position, 2);
    repeat (25) applyStimulus(1'b0, 1'b0, 1'b1);
    checkTime("hr_wrap", 1, 0, 3);
    checkOutput("hr_wrap_pos", o_position, 2);

    // Mode beats inc in the same cycle
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("mode_inc_mode", o_mode, 2);
    checkOutput("mode_inc_pos", o_position, 0);
    checkTime("mode_inc_alarm", 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("back_clock_mode", o_mode, 0);
    checkOutput("back_clock_hr", o_hr, 1);

    // Preload 23:59:59 and roll over on one tick
    applyStimulus(1'b1, 1'b0, 1'b0);
    incUntil(0, 59);
    applyStimulus(1'b0, 1'b1, 1'b0);
    incUntil(1, 59);
    applyStimulus(1'b0, 1'b1, 1'b0);
    incUntil(2, 23);
    checkTime("preload", 23, 59, 59);
    enterClockAligned("roll");
    checkTime("roll_hold", 23, 59, 59);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("roll_tick", o_tick, (k == 3) ? 1 : 0);
      if (k < 4) checkTime("roll_pre", 23, 59, 59);
      else checkTime("roll_post", 0, 0, 0);
    end
    checkOutput("roll_alarm", o_alarm, 0);

    // Alarm: full duration, early stop, then async reset while active
    runAlarm("alarm_full", 0, 36);
    runAlarm("alarm_drop", 24, 28);
    runAlarm("alarm_rst", 0, 22);
    #3;
    rst = 1'b1;
    #1;
    checkTime("async_rst", 0, 0, 0);
    checkOutput("async_rst_alarm", o_alarm, 0);
    checkOutput("async_rst_mode", o_mode, 0);
    checkOutput("async_rst_tick", o_tick, 0);
    i_alarm_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Async reset from SETUP with a non-default position
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("setup2_min", o_min, 3);
    checkOutput("setup2_pos", o_position, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("setup_rst_mode", o_mode, 0);
    checkOutput("setup_rst_pos", o_position, 0);
    checkOutput("setup_rst_min", o_min, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
